ti_adc_os_cal: RTL and testbench
================================

# ti_adc_os_cal

Foreground offset-calibration sequencer for the time-interleaved SAR ADC. It runs on the ADC core clock with the converter inputs held at common mode. For each sub-ADC way in turn, it performs a successive-approximation search on that way's sense-amp offset DAC pair (`data_vosp`/`data_vosn`), using averaged output codes, until each way's mean output sits at mid-scale. Its outputs drive the offset-DAC code inputs of the ADC macro directly.

## Interface
- `ADC_WAYS`, 8, number of interleaved sub-ADCs
- `ADC_BITS`, 9, sub-ADC output width (offset binary, mid-scale = 2^(ADC_BITS-1))
- `OSDAC_BITS`, 8, offset DAC code width
- `AVG_LOG2`, 4, log2 of samples averaged per trial (N = 16)
- `SETTLE_CYC`, 4, clk cycles waited after each code change before accumulating (≥1)

- `clk` in 1: ADC core clock; single clock domain
- `rst_n` in 1: asynchronous, active-low reset
- `cal_start` in 1: level-sampled request; accepted only in IDLE
- `adc_valid` in 1: `adc_data` holds a fresh sample set this cycle
- `adc_data` in `[ADC_WAYS]×ADC_BITS`: per-way conversion results
- `data_vosp` out `[ADC_WAYS]×OSDAC_BITS`: positive offset DAC codes
- `data_vosn` out `[ADC_WAYS]×OSDAC_BITS`: negative offset DAC codes, always bitwise complement of `data_vosp`
- `cal_busy` out 1: calibration in progress
- `cal_done` out 1: one-cycle pulse at end of sweep
- `cal_way` out clog2(ADC_WAYS): way currently under calibration (0 when idle)
- `cal_sat` out ADC_WAYS: per-way flag, final code is all-zeros or all-ones

## Operation
- Trim code `c[w]`: `data_vosp[w]=c[w]`, `data_vosn[w]=~c[w]`. Increasing `c` raises the way's output code.
- Reset values:
  - all `c[w]=2^(OSDAC_BITS-1)` (0x80), so `vosn=0x7F`
  - `cal_busy=0`, `cal_done=0`, `cal_way=0`, `cal_sat=0`
  - state IDLE, accumulator and counters 0
- FSM states: IDLE, SETTLE, ACCUM, DECIDE, DONE.
  - **IDLE** + `cal_start=1`: clear `cal_sat`; set `way=0`, `bit=OSDAC_BITS-1`; set `c[0]=1<<bit` (lower bits cleared); go to SETTLE.
  - **SETTLE**: count SETTLE_CYC clk cycles, ignoring `adc_valid`; clear accumulator; go to ACCUM.
  - **ACCUM**: add `adc_data[way]` on each `adc_valid` cycle only. After 2^AVG_LOG2 accepted samples, go to DECIDE. Stalls indefinitely if `adc_valid` stays low.
  - **DECIDE** (1 cycle):
    - If `sum > 2^(ADC_BITS-1+AVG_LOG2)`, clear `c[way][bit]`; otherwise keep it.
    - If `bit>0`: decrement `bit`, set the new bit in `c[way]`, go to SETTLE.
    - Else: set `cal_sat[way]` if `c[way]` is 0 or all-ones after the decision. If `way<ADC_WAYS-1`, increment `way`, load `c[way]=0x80`-equivalent, go to SETTLE; otherwise go to DONE.
  - **DONE**: `cal_done=1` for one cycle, then IDLE.
- Accumulator width is `ADC_BITS+AVG_LOG2`; it cannot overflow. The compare is unsigned, and equality keeps the bit.
- Ways other than the one under calibration hold their codes. All codes hold after DONE until the next start or reset.
- `cal_start` while busy is ignored; a request held high through DONE starts a new sweep on the first IDLE cycle.
- Reset mid-sweep aborts immediately and restores all reset values, including codes.

## Timing
- `cal_start` high at edge k gives `cal_busy=1` and new `c[0]` at k+1.
- Per-bit cycles with `adc_valid` continuously high: SETTLE_CYC + 2^AVG_LOG2 + 1. Defaults: 21 cycles per bit, 168 per way, 1344 per sweep.
- `cal_done` pulse falls on the cycle after the last DECIDE, with `cal_busy` still 1. `cal_busy` drops on the following cycle.
- Code outputs are registered and change only on DECIDE exit or sweep start.

## Structure
- Package `ti_adc_cal_pkg` holds:
  - the state enum `cal_state_t`
  - a `mid_target(ADC_BITS,AVG_LOG2)` constant function
  - a `clog2` helper
- Sub-module `ti_adc_cal_acc` holds the valid-gated accumulator, sample counter, and threshold compare. Its ports are `clr`, `en`, `din`, `full`, `gt`. The FSM, code registers, and way mux stay in the top level.

## Test plan
- **Reset**: assert `rst_n=0` mid-ACCUM. Expect all `vosp=0x80`, `vosn=0x7F`, `busy=0`, `done=0`, `cal_sat=0` immediately; after release, the FSM stays IDLE.
- **Ideal ADC model**: output = 256 + (c−0x5A)/2 for way 3 and 256 + (c−0x80)/2 for the others. Expect a final `c[3]` of 0x5A, others 0x80, `vosn` equal to the complement, `cal_done` at cycle 1345 after start, and `cal_sat=0`.
- **Saturation**: way 5 model outputs 511 regardless of code. Expect `c[5]=0x00` and `cal_sat=8'b0010_0000`.
- **Valid stall**: hold `adc_valid` low for 50 cycles in way 0 ACCUM. Expect identical final codes and sweep length extended by exactly 50 cycles.
- **Restart handling**: pulse `cal_start` during a sweep and expect no effect. Hold `cal_start` high across DONE and expect a second sweep beginning with `c[0]=0x80` at the cycle after `busy` falls.
- **Equality boundary**: model returns exactly 256 at every code. Expect all bits kept, giving a final `c=0xFF` on every way and `cal_sat` all ones.

Source files
------------

// File: rtl/ti_adc_cal_pkg.sv
// ti_adc_cal_pkg: shared state encoding and constant helpers for the offset-calibration sequencer
package ti_adc_cal_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_ACCUM,
      S_DECIDE,
      S_DONE
   } cal_state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   // Sum of 2^avg_log2 samples sitting exactly at mid-scale.
   function automatic int mid_target(input int adc_bits, input int avg_log2);
      return 1 << (adc_bits - 1 + avg_log2);
   endfunction
endpackage

// File: rtl/ti_adc_cal_acc.sv
// ti_adc_cal_acc: valid-gated sample accumulator with sample counter and mid-scale compare
module ti_adc_cal_acc
   import ti_adc_cal_pkg::*;
#(
   parameter int DW       = 9,
   parameter int AVG_LOG2 = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] din,
   output logic          full,
   output logic          gt
);
   localparam int SW = DW + AVG_LOG2;
   localparam logic [SW-1:0] TGT = SW'(mid_target(DW, AVG_LOG2));
   localparam logic [AVG_LOG2:0] LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);
   logic [SW-1:0] sum;
   logic [AVG_LOG2:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sum <= '0;
         cnt <= '0;
      end else if (clr) begin
         sum <= '0;
         cnt <= '0;
      end else if (en) begin
         sum <= sum + SW'(din);
         cnt <= cnt + 1'b1;
      end
   // full flags the sample that completes the set, so the FSM leaves ACCUM on that edge.
   assign full = en && cnt == LAST;
   assign gt   = sum > TGT;
endmodule

// File: rtl/ti_adc_os_cal.sv
// ti_adc_os_cal: foreground offset-trim sequencer; SAR search of each way's offset DAC
// so the averaged way output lands on mid-scale.
module ti_adc_os_cal
   import ti_adc_cal_pkg::*;
#(
   parameter int ADC_WAYS   = 8,
   parameter int ADC_BITS   = 9,
   parameter int OSDAC_BITS = 8,
   parameter int AVG_LOG2   = 4,
   parameter int SETTLE_CYC = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             cal_start,
   input  logic                             adc_valid,
   input  logic [ADC_WAYS*ADC_BITS-1:0]     adc_data,
   output logic [ADC_WAYS*OSDAC_BITS-1:0]   data_vosp,
   output logic [ADC_WAYS*OSDAC_BITS-1:0]   data_vosn,
   output logic                             cal_busy,
   output logic                             cal_done,
   output logic [clog2(ADC_WAYS)-1:0]       cal_way,
   output logic [ADC_WAYS-1:0]              cal_sat
);
   localparam int WW = clog2(ADC_WAYS);
   localparam int BW = clog2(OSDAC_BITS);
   localparam int SW = clog2(SETTLE_CYC + 1);
   localparam logic [OSDAC_BITS-1:0] MID = {1'b1, {(OSDAC_BITS-1){1'b0}}};
   localparam logic [BW-1:0] MSB = BW'(OSDAC_BITS - 1);
   localparam logic [WW-1:0] LAST = WW'(ADC_WAYS - 1);
   localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE_CYC - 1);
   cal_state_t state;
   logic [OSDAC_BITS-1:0] code [ADC_WAYS];
   logic [BW-1:0] bit_idx;
   logic [SW-1:0] settle_cnt;
   logic [OSDAC_BITS-1:0] bmask;
   logic [OSDAC_BITS-1:0] trial;
   logic acc_full;
   logic acc_gt;
   assign bmask    = OSDAC_BITS'(1) << bit_idx;
   assign trial    = acc_gt ? code[cal_way] & ~bmask : code[cal_way];
   assign cal_busy = state != S_IDLE;
   assign cal_done = state == S_DONE;
   ti_adc_cal_acc #(
      .DW      (ADC_BITS),
      .AVG_LOG2(AVG_LOG2)
   ) u_acc (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (state == S_SETTLE),
      .en   (state == S_ACCUM && adc_valid),
      .din  (adc_data[int'(cal_way)*ADC_BITS +: ADC_BITS]),
      .full (acc_full),
      .gt   (acc_gt)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= S_IDLE;
         cal_way    <= '0;
         bit_idx    <= '0;
         settle_cnt <= '0;
         cal_sat    <= '0;
         for (int i = 0; i < ADC_WAYS; i++) code[i] <= MID;
      end else begin
         case (state)
            S_IDLE:
               if (cal_start) begin
                  cal_sat    <= '0;
                  cal_way    <= '0;
                  bit_idx    <= MSB;
                  settle_cnt <= '0;
                  code[0]    <= MID;
                  state      <= S_SETTLE;
               end
            S_SETTLE:
               if (settle_cnt == SETTLE_END) begin
                  settle_cnt <= '0;
                  state      <= S_ACCUM;
               end else settle_cnt <= settle_cnt + 1'b1;
            S_ACCUM:
               if (acc_full) state <= S_DECIDE;
            S_DECIDE:
               if (bit_idx != '0) begin
                  code[cal_way] <= trial | (bmask >> 1);
                  bit_idx       <= bit_idx - 1'b1;
                  state         <= S_SETTLE;
               end else begin
                  code[cal_way]    <= trial;
                  cal_sat[cal_way] <= trial == '0 || &trial;
                  if (cal_way != LAST) begin
                     cal_way                <= cal_way + 1'b1;
                     code[cal_way + 1'b1]   <= MID;
                     bit_idx                <= MSB;
                     state                  <= S_SETTLE;
                  end else state <= S_DONE;
               end
            S_DONE: begin
               cal_way <= '0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   for (genvar g = 0; g < ADC_WAYS; g++) begin : g_out
      assign data_vosp[g*OSDAC_BITS +: OSDAC_BITS] = code[g];
      assign data_vosn[g*OSDAC_BITS +: OSDAC_BITS] = ~code[g];
   end
endmodule

// File: tb/tb_ti_adc_os_cal.sv
// tb_ti_adc_os_cal: directed/randomized sweeps of the offset calibrator against an ideal
// per-way ADC model; expected codes come from the model's transfer curve.
module tb_ti_adc_os_cal;
   localparam int W  = 8;
   localparam int AB = 9;
   localparam int OB = 8;
   localparam int NONE = 100000;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cal_start = 1'b0;
   logic adc_valid = 1'b1;
   logic [W*AB-1:0] adc_data;
   logic [W*OB-1:0] data_vosp;
   logic [W*OB-1:0] data_vosn;
   logic cal_busy;
   logic cal_done;
   logic [2:0] cal_way;
   logic [W-1:0] cal_sat;
   int total = 0;
   int passed = 0;
   int failed = 0;
   int off [W];
   bit eq_mode = 1'b0;
   int sat_way = -1;
   int len;

   ti_adc_os_cal dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cal_start(cal_start),
      .adc_valid(adc_valid),
      .adc_data (adc_data),
      .data_vosp(data_vosp),
      .data_vosn(data_vosn),
      .cal_busy (cal_busy),
      .cal_done (cal_done),
      .cal_way  (cal_way),
      .cal_sat  (cal_sat)
   );

   always #5 clk = ~clk;

   // Ideal way: half an LSB per trim step around its offset, half-step rounded up.
   function automatic int adc_f(input int w, input int c);
      int v;
      if (eq_mode) return 256;
      if (w == sat_way) return 511;
      v = 256 + ((c - off[w] + 1) >>> 1);
      return v < 0 ? 0 : (v > 511 ? 511 : v);
   endfunction

   // Best trim is the largest code whose mean output does not exceed mid-scale.
   function automatic int ref_code(input int w);
      for (int c = 255; c >= 0; c--)
         if (adc_f(w, c) <= 256) return c;
      return 0;
   endfunction

   always @(negedge clk)
      for (int w = 0; w < W; w++)
         adc_data[w*AB +: AB] = AB'(adc_f(w, int'(data_vosp[w*OB +: OB])));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_codes(input string tag);
      logic [W-1:0] sat_exp;
      sat_exp = '0;
      for (int w = 0; w < W; w++) begin
         int e;
         e = ref_code(w);
         chk($sformatf("%s_vosp%0d", tag, w), 64'(data_vosp[w*OB +: OB]), 64'(e));
         chk($sformatf("%s_vosn%0d", tag, w), 64'(data_vosn[w*OB +: OB]), 64'((~e) & 255));
         sat_exp[w] = (e == 0 || e == 255);
      end
      chk({tag, "_sat"}, 64'(cal_sat), 64'(sat_exp));
   endtask

   task automatic sweep(input int stall_at, input bit gaps, input int pulse_at,
                        input int hold_from, input int abort_at, output int n);
      cal_start = 1'b1;
      adc_valid = 1'b1;
      @(posedge clk); #1;
      cal_start = 1'b0;
      n = 1;
      while (!cal_done && n < 20000 && n != abort_at) begin
         adc_valid = (n >= stall_at && n < stall_at + 50) ? 1'b0 :
                     (gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
         cal_start = (n == pulse_at) || (n >= hold_from);
         if (!gaps && n < stall_at && n % 168 == 84)
            chk("cal_way", 64'(cal_way), 64'(n / 168));
         @(posedge clk); #1;
         n++;
      end
      adc_valid = 1'b1;
      if (abort_at < 0) chk("done_seen", 64'(cal_done), 64'(1));
   endtask

   initial begin
      for (int w = 0; w < W; w++) off[w] = 128;
      #12;
      chk("rst_vosp", data_vosp, {W{8'h80}});
      chk("rst_vosn", data_vosn, {W{8'h7F}});
      chk("rst_busy", 64'(cal_busy), 64'(0));
      chk("rst_done", 64'(cal_done), 64'(0));
      chk("rst_way", 64'(cal_way), 64'(0));
      chk("rst_sat", 64'(cal_sat), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_busy", 64'(cal_busy), 64'(0));
      off[3] = 'h5A;
      sweep(NONE, 1'b0, 600, NONE, -1, len);
      chk("ideal_len", 64'(len), 64'(1345));
      check_codes("ideal");
      chk("ideal_c3", 64'(data_vosp[31:24]), 64'h5A);
      @(posedge clk); #1;
      chk("done_pulse", 64'(cal_done), 64'(0));
      chk("busy_drop", 64'(cal_busy), 64'(0));
      sweep(10, 1'b0, -1, NONE, -1, len);
      chk("stall_len", 64'(len), 64'(1395));
      check_codes("stall");
      @(posedge clk); #1;
      repeat (3) begin
         for (int w = 0; w < W; w++) off[w] = $urandom_range(0, 255);
         sweep(NONE, 1'b1, -1, NONE, -1, len);
         check_codes("rand");
         @(posedge clk); #1;
      end
      for (int w = 0; w < W; w++) off[w] = 128;
      sat_way = 5;
      sweep(NONE, 1'b0, -1, NONE, -1, len);
      check_codes("satur");
      chk("satur_c5", 64'(data_vosp[47:40]), 64'(0));
      chk("satur_vec", 64'(cal_sat), 64'b0010_0000);
      sat_way = -1;
      @(posedge clk); #1;
      off[0] = 'h30;
      sweep(NONE, 1'b0, -1, 1300, -1, len);
      chk("hold_len", 64'(len), 64'(1345));
      chk("hold_c0_before", 64'(data_vosp[7:0]), 64'h30);
      @(posedge clk); #1;
      chk("hold_idle", 64'(cal_busy), 64'(0));
      @(posedge clk); #1;
      chk("hold_restart_busy", 64'(cal_busy), 64'(1));
      chk("hold_restart_c0", 64'(data_vosp[7:0]), 64'h80);
      cal_start = 1'b0;
      len = 1;
      while (!cal_done && len < 20000) begin
         @(posedge clk); #1;
         len++;
      end
      chk("hold_len2", 64'(len), 64'(1345));
      check_codes("hold");
      @(posedge clk); #1;
      eq_mode = 1'b1;
      sweep(NONE, 1'b0, -1, NONE, -1, len);
      check_codes("eq");
      chk("eq_sat", 64'(cal_sat), 64'hFF);
      eq_mode = 1'b0;
      @(posedge clk); #1;
      for (int w = 0; w < W; w++) off[w] = $urandom_range(16, 240);
      off[0] = 'h30;
      sweep(NONE, 1'b0, -1, NONE, 179, len);
      chk("abort_c0", 64'(data_vosp[7:0]), 64'h30);
      rst_n = 1'b0;
      #1;
      chk("arst_vosp", data_vosp, {W{8'h80}});
      chk("arst_vosn", data_vosn, {W{8'h7F}});
      chk("arst_busy", 64'(cal_busy), 64'(0));
      chk("arst_done", 64'(cal_done), 64'(0));
      chk("arst_sat", 64'(cal_sat), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("post_rst_busy", 64'(cal_busy), 64'(0));
      chk("post_rst_vosp", data_vosp, {W{8'h80}});
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
